// File: rtl/hs32_mem_arb.sv
// HS32 memory arbiter: serialises fetch (read-only) and exec (read/write) requests onto one SRAM port.
// Optional build macro HS32_ARB_RR_EN: round-robin tie-breaking instead of fixed exec priority.
module hs32_mem_arb #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addrf,
  input  logic        reqf,
  output logic [31:0] dtrf,
  output logic        ackf,
  input  logic [31:0] addrm,
  input  logic        reqm,
  input  logic        rwm,
  input  logic [31:0] dtwm,
  output logic [31:0] dtrm,
  output logic        ackm,
  output logic [31:0] mem_addr,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        owner_exec_q;
  logic [31:0] mem_addr_q;
  logic        mem_ce_q;
  logic        mem_we_q;
  logic [31:0] mem_din_q;
  logic [31:0] dtrf_q;
  logic [31:0] dtrm_q;
  logic        ackf_q;
  logic        ackm_q;
  logic        grant_exec_d;
  logic        any_req_d;

`ifdef HS32_ARB_RR_EN
  logic        rr_last_exec_q;
`endif

  always_comb begin
    // NOTE: each combinational output is assigned before any branch, so no latch is inferred.
    any_req_d    = reqf | reqm;
    grant_exec_d = reqm;
`ifdef HS32_ARB_RR_EN
    // On a tie the port that did not win last time is served.
    if (reqf && reqm) grant_exec_d = ~rr_last_exec_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      owner_exec_q   <= 1'b1;
      mem_addr_q     <= 32'd0;
      mem_ce_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_din_q      <= 32'd0;
      dtrf_q         <= 32'd0;
      dtrm_q         <= 32'd0;
      ackf_q         <= 1'b0;
      ackm_q         <= 1'b0;
`ifdef HS32_ARB_RR_EN
      rr_last_exec_q <= 1'b1;
`endif
    end else begin
      // Acks are single-cycle pulses; only the end of ACCESS raises one.
      ackf_q <= 1'b0;
      ackm_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            mem_addr_q   <= grant_exec_d ? addrm : addrf;
            mem_ce_q     <= 1'b1;
            mem_we_q     <= grant_exec_d & rwm;
            if (grant_exec_d && rwm) mem_din_q <= dtwm;
            cnt_q        <= WAIT_LD;
            owner_exec_q <= grant_exec_d;
`ifdef HS32_ARB_RR_EN
            rr_last_exec_q <= grant_exec_d;
`endif
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (owner_exec_q) begin
              if (!mem_we_q) dtrm_q <= mem_dout;
              ackm_q <= 1'b1;
            end else begin
              dtrf_q <= mem_dout;
              ackf_q <= 1'b1;
            end
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dtrf     = dtrf_q;
  assign dtrm     = dtrm_q;
  assign ackf     = ackf_q;
  assign ackm     = ackm_q;
  assign mem_addr = mem_addr_q;
  assign mem_ce   = mem_ce_q;
  assign mem_we   = mem_we_q;
  assign mem_din  = mem_din_q;

  a_ack_exclusive: assert property (@(posedge clk) disable iff (!reset) !(ackf_q && ackm_q));
  a_we_needs_ce:   assert property (@(posedge clk) disable iff (!reset) mem_we_q |-> mem_ce_q);
  a_ackf_pulse:    assert property (@(posedge clk) disable iff (!reset) ackf_q |=> !ackf_q);
  a_ackm_pulse:    assert property (@(posedge clk) disable iff (!reset) ackm_q |=> !ackm_q);

endmodule
